// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: picks the highest-priority unmasked request,
// handles the two-pulse INTA handshake, drives the vector byte and maintains the in-service register.
module inta_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INTA,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       eoi_strobe,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       INT,
  output logic [7:0] isr,
  output logic [7:0] irr_highest_bit,
  output logic       reset_irr_bit,
  output logic [1:0] number_of_ack,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACK1 = 2'd1, ACK2 = 2'd2} state_t;

  // Returns {found, index} of the lowest-index set bit (IR0 is highest priority).
  function automatic logic [3:0] lowest_set(input logic [7:0] v);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  state_t     state_q, state_d;
  logic       s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  logic       int_req_q, int_req_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] hb_q, hb_d;
  logic       rib_q, rib_d;
  logic [1:0] nack_q, nack_d;
  logic [7:0] dout_q, dout_d;
  logic       den_q, den_d;
  logic       spurious_q, spurious_d;
  logic [2:0] level_q, level_d;

  logic       fall_s, rise_s;
  logic [3:0] cand_s, blk_s;
  logic [7:0] isr_eoi_s;
  logic [2:0] eoi_tgt_s;

  assign fall_s = s3_q & ~s2_q;
  assign rise_s = ~s3_q & s2_q;
  assign cand_s = lowest_set(irr & ~imr);
  assign blk_s  = lowest_set(isr_q);

  // Next-state, vector and in-service computation.
  always_comb begin
    s1_d       = INTA;
    s2_d       = s1_q;
    s3_d       = s2_q;
    state_d    = state_q;
    int_req_d  = 1'b0;
    hb_d       = hb_q;
    rib_d      = 1'b0;
    nack_d     = nack_q;
    dout_d     = dout_q;
    den_d      = den_q;
    spurious_d = spurious_q;
    level_d    = level_q;

    // EOI is folded in first so a coincident new in-service bit wins.
    isr_eoi_s = isr_q;
    eoi_tgt_s = eoi_specific ? eoi_level : blk_s[2:0];
    if (eoi_strobe && (eoi_specific || blk_s[3])) begin
      isr_eoi_s[eoi_tgt_s] = 1'b0;
    end else begin
      isr_eoi_s = isr_q;
    end
    isr_d = isr_eoi_s;

    case (state_q)
      IDLE: begin
        int_req_d = cand_s[3] && (!blk_s[3] || (cand_s[2:0] < blk_s[2:0]));
        if (fall_s) begin
          state_d   = ACK1;
          int_req_d = 1'b0;
          nack_d    = 2'd1;
          if (cand_s[3]) begin
            hb_d       = 8'h01 << cand_s[2:0];
            isr_d      = isr_eoi_s | (8'h01 << cand_s[2:0]);
            rib_d      = 1'b1;
            spurious_d = 1'b0;
            level_d    = cand_s[2:0];
          end else begin
            hb_d       = 8'h80;
            spurious_d = 1'b1;
            level_d    = 3'd7;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACK1: begin
        if (fall_s) begin
          state_d = ACK2;
          nack_d  = 2'd2;
          dout_d  = {vector_base, level_q};
          den_d   = 1'b1;
        end else begin
          state_d = ACK1;
        end
      end
      ACK2: begin
        if (rise_s) begin
          state_d = IDLE;
          nack_d  = 2'd0;
          dout_d  = 8'h00;
          den_d   = 1'b0;
          if (aeoi && !spurious_q) begin
            isr_d[level_q] = 1'b0;
          end else begin
            isr_d = isr_eoi_s;
          end
        end else begin
          state_d = ACK2;
        end
      end
      default: begin
        state_d = IDLE;
        nack_d  = 2'd0;
        dout_d  = 8'h00;
        den_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      s3_q       <= 1'b1;
      int_req_q  <= 1'b0;
      isr_q      <= 8'h00;
      hb_q       <= 8'h00;
      rib_q      <= 1'b0;
      nack_q     <= 2'd0;
      dout_q     <= 8'h00;
      den_q      <= 1'b0;
      spurious_q <= 1'b0;
      level_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      int_req_q  <= int_req_d;
      isr_q      <= isr_d;
      hb_q       <= hb_d;
      rib_q      <= rib_d;
      nack_q     <= nack_d;
      dout_q     <= dout_d;
      den_q      <= den_d;
      spurious_q <= spurious_d;
      level_q    <= level_d;
    end
  end

  assign INT             = int_req_q;
  assign isr             = isr_q;
  assign irr_highest_bit = hb_q;
  assign reset_irr_bit   = rib_q;
  assign number_of_ack   = nack_q;
  assign data_out        = dout_q;
  assign data_out_en     = den_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: a vector table for priority/vector resolution
// plus hand-written sequences for EOI, auto-EOI, spurious ack and mid-sequence reset.
module tb_inta_sequencer;

  logic       clk;
  logic       rst_n;
  logic       INTA;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       eoi_strobe;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       INT;
  logic [7:0] isr;
  logic [7:0] irr_highest_bit;
  logic       reset_irr_bit;
  logic [1:0] number_of_ack;
  logic [7:0] data_out;
  logic       data_out_en;

  int n_tests = 0;
  int n_fail  = 0;

  inta_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .INTA            (INTA),
    .irr             (irr),
    .imr             (imr),
    .vector_base     (vector_base),
    .aeoi            (aeoi),
    .eoi_strobe      (eoi_strobe),
    .eoi_specific    (eoi_specific),
    .eoi_level       (eoi_level),
    .INT             (INT),
    .isr             (isr),
    .irr_highest_bit (irr_highest_bit),
    .reset_irr_bit   (reset_irr_bit),
    .number_of_ack   (number_of_ack),
    .data_out        (data_out),
    .data_out_en     (data_out_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] vb;
    logic       exp_int;
    logic       exp_pulse;
    logic [7:0] exp_hb;
    logic [7:0] exp_isr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive INTA; the sequencer acts on the third rising edge (3-flop synchroniser).
  task automatic set_inta(input logic v, input logic do_eoi, input logic spec, input logic [2:0] lvl);
    INTA = v;
    tick(2);
    eoi_strobe   = do_eoi;
    eoi_specific = spec;
    eoi_level    = lvl;
    tick(1);
    eoi_strobe   = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = 3'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " INT"},  {7'd0, INT}, 8'h00);
    check({tag, " isr"},  isr, 8'h00);
    check({tag, " hb"},   irr_highest_bit, 8'h00);
    check({tag, " rib"},  {7'd0, reset_irr_bit}, 8'h00);
    check({tag, " nack"}, {6'd0, number_of_ack}, 8'h00);
    check({tag, " dout"}, data_out, 8'h00);
    check({tag, " den"},  {7'd0, data_out_en}, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    INTA  = 1'b1;
    #1;
    check_reset_outputs("reset");
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic full_ack();
    set_inta(1'b0, 1'b0, 1'b0, 3'd0);
    set_inta(1'b1, 1'b0, 1'b0, 3'd0);
    set_inta(1'b0, 1'b0, 1'b0, 3'd0);
    set_inta(1'b1, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0; INTA = 1'b1; irr = 8'h00; imr = 8'h00; vector_base = 5'h00;
    aeoi = 1'b0; eoi_strobe = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;

    vecs[0] = '{8'h24, 8'h00, 5'h10, 1'b1, 1'b1, 8'h04, 8'h04, 8'h82};
    vecs[1] = '{8'h0F, 8'h03, 5'h08, 1'b1, 1'b1, 8'h04, 8'h04, 8'h42};
    vecs[2] = '{8'h80, 8'h00, 5'h1F, 1'b1, 1'b1, 8'h80, 8'h80, 8'hFF};
    vecs[3] = '{8'h01, 8'h00, 5'h05, 1'b1, 1'b1, 8'h01, 8'h01, 8'h28};
    vecs[4] = '{8'hFF, 8'hFF, 5'h11, 1'b0, 1'b0, 8'h80, 8'h00, 8'h8F};
    vecs[5] = '{8'h40, 8'h00, 5'h03, 1'b1, 1'b1, 8'h40, 8'h40, 8'h1E};

    tick(2);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      irr = vecs[i].irr; imr = vecs[i].imr; vector_base = vecs[i].vb;
      tick(2);
      check($sformatf("v%0d INT", i), {7'd0, INT}, {7'd0, vecs[i].exp_int});
      set_inta(1'b0, 1'b0, 1'b0, 3'd0);
      check($sformatf("v%0d nack1", i), {6'd0, number_of_ack}, 8'h01);
      check($sformatf("v%0d hb", i), irr_highest_bit, vecs[i].exp_hb);
      check($sformatf("v%0d rib", i), {7'd0, reset_irr_bit}, {7'd0, vecs[i].exp_pulse});
      check($sformatf("v%0d isr", i), isr, vecs[i].exp_isr);
      check($sformatf("v%0d INT ack1", i), {7'd0, INT}, 8'h00);
      tick(1);
      check($sformatf("v%0d rib end", i), {7'd0, reset_irr_bit}, 8'h00);
      set_inta(1'b1, 1'b0, 1'b0, 3'd0);
      check($sformatf("v%0d nack rise1", i), {6'd0, number_of_ack}, 8'h01);
      check($sformatf("v%0d den rise1", i), {7'd0, data_out_en}, 8'h00);
      check($sformatf("v%0d dout idle", i), data_out, 8'h00);
      set_inta(1'b0, 1'b0, 1'b0, 3'd0);
      check($sformatf("v%0d nack2", i), {6'd0, number_of_ack}, 8'h02);
      check($sformatf("v%0d den", i), {7'd0, data_out_en}, 8'h01);
      check($sformatf("v%0d dout", i), data_out, vecs[i].exp_dout);
      set_inta(1'b1, 1'b0, 1'b0, 3'd0);
      check($sformatf("v%0d den off", i), {7'd0, data_out_en}, 8'h00);
      check($sformatf("v%0d dout off", i), data_out, 8'h00);
      check($sformatf("v%0d nack0", i), {6'd0, number_of_ack}, 8'h00);
      check($sformatf("v%0d hb hold", i), irr_highest_bit, vecs[i].exp_hb);
      check($sformatf("v%0d isr hold", i), isr, vecs[i].exp_isr);
    end

    // Lower-priority request blocked by in-service level 2 until a non-specific EOI.
    do_reset();
    irr = 8'h04; vector_base = 5'h10;
    tick(2);
    full_ack();
    irr = 8'h10;
    tick(2);
    check("blk isr", isr, 8'h04);
    check("blk INT", {7'd0, INT}, 8'h00);
    eoi_strobe = 1'b1;
    tick(1);
    eoi_strobe = 1'b0;
    check("eoi isr", isr, 8'h00);
    tick(1);
    check("eoi INT", {7'd0, INT}, 8'h01);

    // Auto-EOI clears the in-service bit on the closing rise.
    do_reset();
    aeoi = 1'b1; irr = 8'h01;
    tick(2);
    set_inta(1'b0, 1'b0, 1'b0, 3'd0);
    set_inta(1'b1, 1'b0, 1'b0, 3'd0);
    set_inta(1'b0, 1'b0, 1'b0, 3'd0);
    check("aeoi isr ack2", isr, 8'h01);
    set_inta(1'b1, 1'b0, 1'b0, 3'd0);
    check("aeoi isr", isr, 8'h00);
    check("aeoi nack", {6'd0, number_of_ack}, 8'h00);
    aeoi = 1'b0;

    // Request withdrawn after INT: spurious acknowledge reports level 7.
    do_reset();
    irr = 8'h24;
    tick(2);
    check("spur INT", {7'd0, INT}, 8'h01);
    irr = 8'h00; vector_base = 5'h0A;
    set_inta(1'b0, 1'b0, 1'b0, 3'd0);
    check("spur hb", irr_highest_bit, 8'h80);
    check("spur rib", {7'd0, reset_irr_bit}, 8'h00);
    check("spur isr", isr, 8'h00);
    set_inta(1'b1, 1'b0, 1'b0, 3'd0);
    set_inta(1'b0, 1'b0, 1'b0, 3'd0);
    check("spur dout", data_out, 8'h57);

    // Specific EOI for level 3 coincident with the first fall that sets level 1.
    do_reset();
    irr = 8'h08;
    tick(2);
    full_ack();
    check("pre isr", isr, 8'h08);
    irr = 8'h02;
    tick(2);
    check("pre INT", {7'd0, INT}, 8'h01);
    set_inta(1'b0, 1'b1, 1'b1, 3'd3);
    check("coinc isr", isr, 8'h02);
    check("coinc hb", irr_highest_bit, 8'h02);

    // Asynchronous reset while the vector is on the bus.
    do_reset();
    irr = 8'h04; vector_base = 5'h10;
    tick(2);
    set_inta(1'b0, 1'b0, 1'b0, 3'd0);
    set_inta(1'b1, 1'b0, 1'b0, 3'd0);
    set_inta(1'b0, 1'b0, 1'b0, 3'd0);
    check("mid den", {7'd0, data_out_en}, 8'h01);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    INTA = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("post nack", {6'd0, number_of_ack}, 8'h00);
    set_inta(1'b0, 1'b0, 1'b0, 3'd0);
    check("post nack1", {6'd0, number_of_ack}, 8'h01);
    check("post hb", irr_highest_bit, 8'h04);
    check("post isr", isr, 8'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: INTA  input  1  CPU interrupt-acknowledge pin, active-low, asynchronous to clk.
REQ-004 SHALL have port: irr  input  8  pending request register from the request stage.
REQ-005 SHALL have port: imr  input  8  interrupt mask; 1 = masked.
REQ-006 SHALL have ports: vector_base  input  5 (T7..T3); aeoi  input  1  auto-EOI mode.
REQ-007 SHALL have ports: eoi_strobe  input  1  one-clk EOI command; eoi_specific  input  1; eoi_level  input  3.
REQ-008 SHALL have port: INT  output  1  interrupt request to CPU, active-high, registered.
REQ-009 SHALL have port: isr  output  8  in-service register.
REQ-010 SHALL have ports: irr_highest_bit  output  8  one-hot selected level; reset_irr_bit  output  1  one-clk clear pulse.
REQ-011 SHALL have port: number_of_ack  output  2  INTA pulses seen in current sequence (0, 1, 2).
REQ-012 SHALL have ports: data_out  output  8  vector byte; data_out_en  output  1  bus drive enable.

Function
REQ-013 SHALL synchronise INTA through three flops s1->s2->s3; fall = s3 & ~s2, rise = ~s3 & s2.
REQ-014 SHALL use fixed priority, IR0 highest, IR7 lowest; req = irr & ~imr.
REQ-015 SHALL compute cand = lowest-index set bit of req, and block = lowest-index set bit of isr.
REQ-016 SHALL register INT = 1 when state IDLE and cand exists with index < block index (or isr == 0); INT is visible one clk after condition.
REQ-017 SHALL implement states IDLE, ACK1, ACK2.
REQ-018 IDLE->ACK1 on fall: latch irr_highest_bit = one-hot(cand), set isr[cand], assert reset_irr_bit for exactly one clk, number_of_ack = 1, INT = 0.
REQ-019 Spurious ack (fall in IDLE, no cand): irr_highest_bit = 8'h80, isr unchanged, no reset_irr_bit pulse, sequence continues; vector reports level 7.
REQ-020 ACK1->ACK2 on fall: number_of_ack = 2; data_out = {vector_base, level[2:0]}; data_out_en = 1 from that clk until rise.
REQ-021 ACK2->IDLE on rise: data_out_en = 0, number_of_ack = 0; if aeoi and not spurious, clear the isr bit set in REQ-018 in the same clk.
REQ-022 rise in ACK1 SHALL NOT change state; fall while data_out_en = 1 SHALL be impossible (rise precedes it).
REQ-023 irr_highest_bit SHALL stay stable from the ACK1 entry until the next IDLE->ACK1 transition.
REQ-024 On eoi_strobe: non-specific (eoi_specific = 0) clears the lowest-index set isr bit; specific clears isr[eoi_level]; no-op if target bit is 0.
REQ-025 eoi_strobe coincident with IDLE->ACK1: EOI clear applied first, then new isr bit set; both take effect in the same clk.
REQ-026 INT SHALL be held 0 in ACK1 and ACK2; re-evaluated from the first IDLE clk.
REQ-027 data_out SHALL be 8'h00 whenever data_out_en = 0.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, INT 0, isr 8'h00, irr_highest_bit 8'h00, reset_irr_bit 0, number_of_ack 0, data_out 8'h00, data_out_en 0, s1/s2/s3 = 1.
REQ-029 Reset mid-sequence SHALL abort it; no vector driven; after release first fall is treated as IDLE->ACK1.

Verification
REQ-030 irr = 8'h24, imr = 0, isr = 0 -> INT = 1; two INTA pulses, vector_base = 5'h10 -> irr_highest_bit = 8'h04, one reset_irr_bit pulse, isr = 8'h04, data_out = 8'h82.
REQ-031 isr = 8'h04, irr = 8'h10 -> INT stays 0; non-specific EOI -> isr = 8'h00, INT = 1 next clk.
REQ-032 aeoi = 1, irr = 8'h01 -> after second INTA rise isr = 8'h00, number_of_ack back to 0.
REQ-033 INT asserted, irr drops to 8'h00 before first INTA -> spurious: isr unchanged, no reset_irr_bit, data_out = {vector_base, 3'b111}.
REQ-034 eoi_strobe specific level 3 coincident with first-INTA fall, isr = 8'h08, cand = 1 -> isr = 8'h02.
REQ-035 rst_n low while data_out_en = 1 -> all outputs per REQ-028 immediately, without waiting for clk.
